// File: rtl/demux_2b_if.sv
// Bus bundle for demux_2b: single producer port plus two consumer lanes.
// The slave modport is the demux side; master is the producer/consumer side.
interface demux_2b_if #(
   parameter int unsigned WIDTH = 2
) ();
   logic             valid_in;
   logic             selector;
   logic [WIDTH-1:0] data_in;
   logic             ready_in;
   logic [WIDTH-1:0] data_out0;
   logic [WIDTH-1:0] data_out1;
   logic             valid_out0;
   logic             valid_out1;
   logic             pop0;
   logic             pop1;
   logic             full0;
   logic             full1;
   logic             overflow;

   modport master (
      output valid_in, selector, data_in, pop0, pop1,
      input  ready_in, data_out0, data_out1, valid_out0, valid_out1, full0, full1, overflow
   );

   modport slave (
      input  valid_in, selector, data_in, pop0, pop1,
      output ready_in, data_out0, data_out1, valid_out0, valid_out1, full0, full1, overflow
   );
endinterface

// File: rtl/demux_2b.sv
// Two-lane buffered demultiplexer: each input word is steered by selector into one of two
// independent DEPTH-entry FIFOs, with per-lane pop handshakes and a sticky overflow flag.
module demux_2b #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 4
) (
   input logic        clk,
   input logic        reset,
   demux_2b_if.slave  bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);
   localparam logic [AW:0] CntOne   = (AW + 1)'(1);

   logic [WIDTH-1:0] mem_q    [2][DEPTH];
   logic [AW-1:0]    wr_ptr_q [2];
   logic [AW-1:0]    wr_ptr_d [2];
   logic [AW-1:0]    rd_ptr_q [2];
   logic [AW-1:0]    rd_ptr_d [2];
   logic [AW:0]      cnt_q    [2];
   logic [AW:0]      cnt_d    [2];
   logic             overflow_q;
   logic             overflow_d;

   logic [1:0] pop_req;
   logic [1:0] lane_valid;
   logic [1:0] lane_full;
   logic [1:0] push_go;
   logic [1:0] pop_go;
   logic       ready;

   assign pop_req = {bus.pop1, bus.pop0};

   // Full/empty come from the count alone; pointer equality is ambiguous.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         lane_valid[n] = (cnt_q[n] != '0);
         lane_full[n]  = (cnt_q[n] == DepthCnt);
      end
   end

   // A full lane popped this cycle frees a slot for the incoming word.
   assign ready = !lane_full[bus.selector] || pop_req[bus.selector];

   always_comb begin
      overflow_d = overflow_q | (bus.valid_in & ~ready);
      for (int n = 0; n < 2; n++) begin
         push_go[n]  = bus.valid_in & ready & (bus.selector == 1'(n));
         pop_go[n]   = pop_req[n] & lane_valid[n];
         wr_ptr_d[n] = wr_ptr_q[n] + AW'(push_go[n]);
         rd_ptr_d[n] = rd_ptr_q[n] + AW'(pop_go[n]);
         cnt_d[n]    = cnt_q[n];
         unique case ({push_go[n], pop_go[n]})
            2'b10:   cnt_d[n] = cnt_q[n] + CntOne;
            2'b01:   cnt_d[n] = cnt_q[n] - CntOne;
            default: cnt_d[n] = cnt_q[n];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
         for (int n = 0; n < 2; n++) begin
            wr_ptr_q[n] <= '0;
            rd_ptr_q[n] <= '0;
            cnt_q[n]    <= '0;
         end
      end else begin
         overflow_q <= overflow_d;
         for (int n = 0; n < 2; n++) begin
            wr_ptr_q[n] <= wr_ptr_d[n];
            rd_ptr_q[n] <= rd_ptr_d[n];
            cnt_q[n]    <= cnt_d[n];
         end
      end
   end

   // Storage carries no reset; stale entries are masked by the count.
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (!reset && push_go[n]) begin
            mem_q[n][wr_ptr_q[n]] <= bus.data_in;
         end
      end
   end

   assign bus.ready_in   = ready;
   assign bus.valid_out0 = lane_valid[0];
   assign bus.valid_out1 = lane_valid[1];
   assign bus.data_out0  = lane_valid[0] ? mem_q[0][rd_ptr_q[0]] : '0;
   assign bus.data_out1  = lane_valid[1] ? mem_q[1][rd_ptr_q[1]] : '0;
   assign bus.full0      = lane_full[0];
   assign bus.full1      = lane_full[1];
   assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_demux_2b.sv
// Self-checking bench for demux_2b: per-lane scoreboard queues filled on accepted pushes
// and compared against the lane heads when words are popped.
module tb_demux_2b;
   localparam int WIDTH = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   demux_2b_if #(.WIDTH(WIDTH)) dif ();

   demux_2b #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif.slave)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   logic [WIDTH-1:0] q0[$];
   logic [WIDTH-1:0] q1[$];
   int               cnt0;
   int               cnt1;
   logic             ovf_m;

   task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic p0, input logic p1);
      dif.valid_in = v;
      dif.selector = s;
      dif.data_in  = d;
      dif.pop0     = p0;
      dif.pop1     = p1;
      #1;
   endtask

   // Advance the reference model with the currently driven inputs, then clock the DUT.
   task automatic tick();
      logic rdy, p0e, p1e;
      rdy = dif.selector ? (cnt1 != DEPTH || dif.pop1) : (cnt0 != DEPTH || dif.pop0);
      p0e = dif.pop0 && (cnt0 != 0);
      p1e = dif.pop1 && (cnt1 != 0);
      if (reset) begin
         q0.delete();
         q1.delete();
         cnt0  = 0;
         cnt1  = 0;
         ovf_m = 1'b0;
      end else begin
         if (p0e) begin void'(q0.pop_front()); cnt0--; end
         if (p1e) begin void'(q1.pop_front()); cnt1--; end
         if (dif.valid_in) begin
            if (!rdy) ovf_m = 1'b1;
            else if (dif.selector) begin q1.push_back(dif.data_in); cnt1++; end
            else begin q0.push_back(dif.data_in); cnt0++; end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [2*WIDTH+5:0] got, want;
      reset = 1'b1;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      got = {dif.valid_out0, dif.valid_out1, dif.data_out0, dif.data_out1,
             dif.full0, dif.full1, dif.overflow, dif.ready_in};
      want    = '0;
      want[0] = 1'b1;
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %b want %b", got, want);
      end
   endtask

   task automatic test_first_push();
      drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tests_run++;
      if (dif.valid_out1 !== 1'b1 || dif.data_out1 !== 2'b10) begin
         tests_failed++;
         $display("FAIL first_push_lane1: got v=%b d=%b want v=1 d=10",
                  dif.valid_out1, dif.data_out1);
      end
      tests_run++;
      if (dif.valid_out0 !== 1'b0 || dif.data_out0 !== '0) begin
         tests_failed++;
         $display("FAIL first_push_lane0_empty: got v=%b d=%b want v=0 d=00",
                  dif.valid_out0, dif.data_out0);
      end
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      tests_run++;
      if (q1.size() == 0 || dif.data_out1 !== q1[0]) begin
         tests_failed++;
         $display("FAIL first_push_pop: got %b want %b", dif.data_out1, q1[0]);
      end
      tick();
   endtask

   task automatic test_alternate();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'(i % 2), WIDTH'(i % 4), 1'b0, 1'b0);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
         tests_run++;
         if (q0.size() == 0 || dif.valid_out0 !== 1'b1 || dif.data_out0 !== q0[0] ||
             dif.data_out0 !== WIDTH'(2 * (k % 2))) begin
            tests_failed++;
            $display("FAIL alt_lane0[%0d]: got %0d want %0d", k, dif.data_out0, 2 * (k % 2));
         end
         tests_run++;
         if (q1.size() == 0 || dif.valid_out1 !== 1'b1 || dif.data_out1 !== q1[0] ||
             dif.data_out1 !== WIDTH'(2 * (k % 2) + 1)) begin
            tests_failed++;
            $display("FAIL alt_lane1[%0d]: got %0d want %0d", k, dif.data_out1,
                     2 * (k % 2) + 1);
         end
         tick();
      end
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tests_run++;
      if (dif.valid_out0 !== 1'b0 || dif.valid_out1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL alt_drained: got v0=%b v1=%b want 0 0", dif.valid_out0, dif.valid_out1);
      end
   endtask

   task automatic test_fill_overflow();
      logic [WIDTH-1:0] vals[4];
      vals = '{2'd3, 2'd1, 2'd2, 2'd0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, vals[i], 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      tests_run++;
      if (dif.full0 !== 1'b1 || dif.ready_in !== 1'b0) begin
         tests_failed++;
         $display("FAIL fill_full0: got full=%b ready=%b want full=1 ready=0",
                  dif.full0, dif.ready_in);
      end
      drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
      tests_run++;
      if (dif.ready_in !== 1'b1) begin
         tests_failed++;
         $display("FAIL fill_ready_sel1: got %b want 1", dif.ready_in);
      end
      drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tests_run++;
      if (dif.overflow !== ovf_m || dif.overflow !== 1'b1 || dif.full0 !== 1'b1) begin
         tests_failed++;
         $display("FAIL drop_overflow: got ovf=%b full=%b want ovf=1 full=1",
                  dif.overflow, dif.full0);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
         tests_run++;
         if (q0.size() == 0 || dif.data_out0 !== q0[0] || dif.data_out0 !== vals[k]) begin
            tests_failed++;
            $display("FAIL drop_contents[%0d]: got %0d want %0d", k, dif.data_out0, vals[k]);
         end
         tick();
      end
   endtask

   task automatic test_full_push_pop();
      logic [WIDTH-1:0] order[4];
      order = '{2'd1, 2'd2, 2'd3, 2'd2};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
      tests_run++;
      if (dif.ready_in !== 1'b1 || dif.data_out0 !== 2'd0) begin
         tests_failed++;
         $display("FAIL fullpp_ready: got ready=%b d=%0d want ready=1 d=0",
                  dif.ready_in, dif.data_out0);
      end
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tests_run++;
      if (dif.full0 !== 1'b1 || dif.overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL fullpp_state: got full=%b ovf=%b want full=1 ovf=0",
                  dif.full0, dif.overflow);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
         tests_run++;
         if (q0.size() == 0 || dif.data_out0 !== q0[0] || dif.data_out0 !== order[k]) begin
            tests_failed++;
            $display("FAIL fullpp_order[%0d]: got %0d want %0d", k, dif.data_out0, order[k]);
         end
         tick();
      end
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, WIDTH'(i), 1'b0, 1'b1);
         if (i > 0) begin
            tests_run++;
            if (q1.size() == 0 || dif.valid_out1 !== 1'b1 || dif.data_out1 !== q1[0] ||
                dif.data_out1 !== WIDTH'(i - 1)) begin
               tests_failed++;
               $display("FAIL stream[%0d]: got %0d want %0d", i, dif.data_out1, (i - 1) % 4);
            end
         end
         tick();
         tests_run++;
         if (dif.full1 !== 1'b0 || dif.valid_out1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL stream_level[%0d]: got full=%b v=%b want full=0 v=1",
                     i, dif.full1, dif.valid_out1);
         end
      end
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      tests_run++;
      if (dif.data_out1 !== WIDTH'(9)) begin
         tests_failed++;
         $display("FAIL stream_last: got %0d want %0d", dif.data_out1, 9 % 4);
      end
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tests_run++;
      if (dif.valid_out1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL stream_empty: got v=%b want 0", dif.valid_out1);
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      for (int i = 1; i < 4; i++) begin
         drive(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0);
         tick();
      end
      reset = 1'b1;
      drive(1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tests_run++;
      if (dif.valid_out0 !== 1'b0 || dif.overflow !== 1'b0 || dif.data_out0 !== '0 ||
          dif.ready_in !== 1'b1) begin
         tests_failed++;
         $display("FAIL midop_reset: got v=%b ovf=%b d=%b rdy=%b want 0 0 00 1",
                  dif.valid_out0, dif.overflow, dif.data_out0, dif.ready_in);
      end
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      tests_run++;
      if (q0.size() != 1 || dif.valid_out0 !== 1'b1 || dif.data_out0 !== q0[0]) begin
         tests_failed++;
         $display("FAIL midop_restart: got v=%b d=%b want v=1 d=10",
                  dif.valid_out0, dif.data_out0);
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      cnt0  = 0;
      cnt1  = 0;
      ovf_m = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      test_reset();
      test_first_push();
      test_alternate();
      test_fill_overflow();
      test_full_push_pop();
      test_stream();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
